// File: rtl/fp16_add_arbiter_if.sv
// Requester-side bundle of the shared fp16 adder arbiter.
// master = compute units, slave = arbiter.
interface fp16_add_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    resp_valid;
  logic [15:0]         resp_result;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one pipelined fp16 adder among N_REQ requesters.
// Ports: clk_in/rst_n, enable, bus (requester side), add_* (adder), idle, tag_err.
module fp16_add_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               enable,
  fp16_add_arbiter_if.slave  bus,
  output logic [15:0]        add_a,
  output logic [15:0]        add_b,
  output logic               add_valid_in,
  input  logic [15:0]        add_result,
  input  logic               add_valid_out,
  output logic               idle,
  output logic               tag_err
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_flush;
  logic [LATENCY-1:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [LATENCY];
  logic               r_tag_err;

  logic               w_found;
  logic               w_grant;
  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_tag_v;
  logic [ID_W-1:0]    w_tag_id;
  logic               w_resp;

  // First pending requester scanning upward from the pointer.
  always_comb begin
    w_found  = 1'b0;
    w_cand   = '0;
    w_gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_gnt_id = w_cand;
      end
    end
  end

  // No grants while stale adder traffic may still emerge.
  assign w_grant  = w_found & enable & (r_flush == '0);
  assign w_tag_v  = r_tag_v[LATENCY-1];
  assign w_tag_id = r_tag_id[LATENCY-1];
  assign w_resp   = add_valid_out & w_tag_v;

  always_comb begin
    add_a           = '0;
    add_b           = '0;
    bus.req_ready   = '0;
    bus.resp_valid  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant && w_gnt_id == ID_W'(i)) begin
        bus.req_ready[i] = 1'b1;
        add_a            = bus.req_a[16*i +: 16];
        add_b            = bus.req_b[16*i +: 16];
      end
      if (w_resp && w_tag_id == ID_W'(i)) begin
        bus.resp_valid[i] = 1'b1;
      end
    end
  end

  assign bus.resp_result = w_resp ? add_result : 16'h0000;
  assign add_valid_in    = w_grant;
  assign idle            = !w_grant && (r_tag_v == '0);
  assign tag_err         = r_tag_err;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_flush   <= CNT_W'(LATENCY);
      r_tag_v   <= '0;
      r_tag_err <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      if (r_flush != '0) begin
        r_flush <= r_flush - CNT_W'(1);
      end
      if (w_grant) begin
        if (w_gnt_id == ID_W'(N_REQ - 1)) begin
          r_rr_ptr <= '0;
        end else begin
          r_rr_ptr <= w_gnt_id + ID_W'(1);
        end
      end
      r_tag_v[0]  <= w_grant;
      r_tag_id[0] <= w_gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      if (r_flush == '0 && add_valid_out != w_tag_v) begin
        r_tag_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: adder model, requester drivers, scoreboard.
// Table vectors plus hand sequences for arbitration, drain, reset, errors.
module tb_fp16_add_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 4;
  localparam int NV  = 10;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] exp;
    int          cyc;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_valid_in;
  logic [15:0] add_result;
  logic        add_valid_out;
  logic        idle;
  logic        tag_err;

  fp16_add_arbiter_if #(.N_REQ(NR)) bus ();

  fp16_add_arbiter #(.N_REQ(NR), .LATENCY(LAT)) dut (
    .clk_in        (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .bus           (bus),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_valid_in  (add_valid_in),
    .add_result    (add_result),
    .add_valid_out (add_valid_out),
    .idle          (idle),
    .tag_err       (tag_err)
  );

  vec_t        tab [NV];
  sb_t         sb [$];
  int          gq [$];
  int          pq [NR][$];
  logic [15:0] cur_exp [NR];
  logic [NR-1:0] acc = '0;
  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_resp = 0;
  int          cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Positive-normal fp16 add, exact for the table operands.
  function automatic logic [15:0] fp_add(logic [15:0] a, logic [15:0] b);
    logic [15:0] t;
    logic [4:0]  e;
    logic [11:0] ma, mb, s;
    if (a[14:10] < b[14:10]) begin
      t = a; a = b; b = t;
    end
    e  = a[14:10];
    ma = {2'b01, a[9:0]};
    mb = {2'b01, b[9:0]};
    mb = mb >> (a[14:10] - b[14:10]);
    s  = ma + mb;
    if (s[11]) begin
      s = s >> 1;
      e = e + 5'd1;
    end
    return {1'b0, e, s[9:0]};
  endfunction

  // Adder model: not reset, so pre-reset ops still emerge.
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pr [LAT];
  logic           inject = 1'b0;

  initial for (int i = 0; i < LAT; i++) pr[i] = '0;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], add_valid_in};
    pr[0] <= fp_add(add_a, add_b);
    for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
  end

  assign add_valid_out = pv[LAT-1] | inject;
  assign add_result    = pr[LAT-1];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    acc = bus.req_valid & bus.req_ready;
    if (rst_n) begin
      if (bus.req_ready != '0)
        chk("ready_onehot", 32'($onehot(bus.req_ready)), 1);
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          sb.push_back('{id: i, exp: cur_exp[i], cyc: cyc});
          gq.push_back(i);
        end
      end
      if (bus.resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(bus.resp_valid), 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          n_resp++;
          chk("resp_id", 32'(bus.resp_valid), 32'(1 << e.id));
          chk("resp_data", 32'(bus.resp_result), 32'(e.exp));
          chk("resp_lat", cyc - e.cyc, LAT);
        end
      end else begin
        chk("resp_idle_zero", 32'(bus.resp_result), 0);
      end
    end
  end

  task automatic load(int i);
    if (pq[i].size() > 0) begin
      int k;
      k = pq[i].pop_front();
      bus.req_a[16*i +: 16] = tab[k].a;
      bus.req_b[16*i +: 16] = tab[k].b;
      cur_exp[i]            = tab[k].exp;
      bus.req_valid[i]      = 1'b1;
    end else begin
      bus.req_a[16*i +: 16] = '0;
      bus.req_b[16*i +: 16] = '0;
      bus.req_valid[i]      = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) load(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    sb.delete();
    for (int i = 0; i < NR; i++) pq[i].delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 1) step();
    gq.delete();
  endtask

  task automatic run_quiet(string nm, int maxc);
    int n;
    n = 0;
    while ((bus.req_valid != '0 || sb.size() != 0 || !idle) && n < maxc) begin
      step();
      n++;
    end
    chk({nm, "_drain"}, 32'(n < maxc), 1);
    chk({nm, "_tagerr"}, 32'(tag_err), 0);
  endtask

  initial begin
    int n;
    int r0;
    tab[0] = '{16'h3C00, 16'h3C00, 16'h4000};
    tab[1] = '{16'h4000, 16'h4000, 16'h4400};
    tab[2] = '{16'h3C00, 16'h4000, 16'h4200};
    tab[3] = '{16'h3800, 16'h3800, 16'h3C00};
    tab[4] = '{16'h4200, 16'h3C00, 16'h4400};
    tab[5] = '{16'h4400, 16'h4400, 16'h4800};
    tab[6] = '{16'h3C00, 16'h3800, 16'h3E00};
    tab[7] = '{16'h4500, 16'h3C00, 16'h4600};
    tab[8] = '{16'h4800, 16'h4000, 16'h4900};
    tab[9] = '{16'h3E00, 16'h3E00, 16'h4200};

    // Reset state.
    rst_n = 1'b0;
    enable = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_resp", 32'(bus.resp_valid), 0);
    chk("rst_addv", 32'(add_valid_in), 0);
    chk("rst_adda", 32'(add_a), 0);
    chk("rst_addb", 32'(add_b), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_tagerr", 32'(tag_err), 0);
    do_reset();

    // Single requester.
    pq[0].push_back(0);
    load(0);
    #1;
    chk("single_ready", 32'(bus.req_ready), 1);
    chk("single_addv", 32'(add_valid_in), 1);
    chk("single_adda", 32'(add_a), 32'h3C00);
    r0 = n_resp;
    run_quiet("single", 20);
    chk("single_nresp", n_resp - r0, 1);

    // All four requesters from the table, round-robin order.
    do_reset();
    for (int v = 0; v < NV; v++) pq[v % NR].push_back(v);
    for (int i = 0; i < NR; i++) load(i);
    run_quiet("rr4", 60);
    chk("rr4_count", gq.size(), NV);
    for (int k = 0; k < gq.size(); k++) chk("rr4_order", gq[k], k % NR);

    // Pointer at 2 with req1 and req3 pending.
    do_reset();
    pq[1].push_back(0);
    load(1);
    run_quiet("ptr_a", 20);
    pq[1].push_back(1);
    pq[3].push_back(2);
    load(1);
    load(3);
    run_quiet("ptr_b", 20);
    pq[1].push_back(3);
    pq[2].push_back(4);
    load(1);
    load(2);
    run_quiet("ptr_c", 20);
    chk("ptr_count", gq.size(), 5);
    if (gq.size() == 5) begin
      chk("ptr_g0", gq[0], 1);
      chk("ptr_g1", gq[1], 3);
      chk("ptr_g2", gq[2], 1);
      chk("ptr_g3", gq[3], 2);
      chk("ptr_g4", gq[4], 1);
    end

    // Drain with enable low.
    do_reset();
    pq[0].push_back(5);
    pq[1].push_back(6);
    pq[2].push_back(7);
    load(0);
    load(1);
    load(2);
    r0 = n_resp;
    repeat (3) step();
    enable = 1'b0;
    pq[3].push_back(8);
    load(3);
    repeat (8) begin
      step();
      chk("en0_noready", 32'(bus.req_ready), 0);
    end
    chk("en0_nresp", n_resp - r0, 3);
    chk("en0_idle", 32'(idle), 1);
    chk("en0_grants", gq.size(), 3);
    enable = 1'b1;
    run_quiet("en1", 20);
    chk("en1_grants", gq.size(), 4);

    // Reset with two ops in flight.
    do_reset();
    pq[0].push_back(8);
    pq[1].push_back(9);
    load(0);
    load(1);
    step();
    step();
    rst_n = 1'b0;
    sb.delete();
    r0 = n_resp;
    @(posedge clk);
    #1 rst_n = 1'b1;
    gq.delete();
    pq[2].push_back(2);
    load(2);
    n = 0;
    while (gq.size() == 0 && n < 20) begin
      step();
      n++;
    end
    chk("rst_first_grant", n - 1, LAT);
    run_quiet("rstmid", 20);
    chk("rstmid_nresp", n_resp - r0, 1);

    // Spurious adder output.
    do_reset();
    inject = 1'b1;
    @(negedge clk);
    chk("spur_resp", 32'(bus.resp_valid), 0);
    chk("spur_err_now", 32'(tag_err), 0);
    @(posedge clk);
    #1 inject = 1'b0;
    chk("spur_err_next", 32'(tag_err), 1);
    repeat (3) step();
    chk("spur_err_sticky", 32'(tag_err), 1);
    chk("spur_resp_after", 32'(bus.resp_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
